// File: rtl/keccak_pkg.sv
// rtl/keccak_pkg.sv - shared Keccak lane geometry, rho offsets and FSM encoding
package keccak_pkg;

   localparam int LANE_W    = 64;
   localparam int NUM_LANES = 25;

   typedef logic [5:0] rho_off_t;

   // Shared with the forward rho block; index is the flat lane number x + 5*y.
   localparam rho_off_t RHO_OFFSETS [NUM_LANES] = '{
      6'd0,  6'd1,  6'd62, 6'd28, 6'd27,
      6'd36, 6'd44, 6'd6,  6'd55, 6'd20,
      6'd3,  6'd10, 6'd43, 6'd25, 6'd39,
      6'd41, 6'd45, 6'd15, 6'd21, 6'd8,
      6'd18, 6'd2,  6'd61, 6'd56, 6'd14
   };

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } rho_state_e;

   function automatic int lane_lsb(input logic [4:0] idx);
      return int'(idx) * LANE_W;
   endfunction

endpackage

// File: rtl/rho_inv_round_if.sv
// rtl/rho_inv_round_if.sv - start/busy/done handshake and state buses of rho_inv_round
interface rho_inv_round_if;
   import keccak_pkg::*;

   logic                            start;
   logic [NUM_LANES*LANE_W-1:0]     state;
   logic                            busy;
   logic                            done;
   logic [NUM_LANES*LANE_W-1:0]     rho_inv_transform;
   logic                            check_err;

   modport master (
      output start, state,
      input  busy, done, rho_inv_transform, check_err
   );

   modport slave (
      input  start, state,
      output busy, done, rho_inv_transform, check_err
   );

endinterface

// File: rtl/rotr64.sv
// rtl/rotr64.sv - combinational 64-bit rotate right by a 6-bit amount
module rotr64 (
   input  logic [63:0] x_i,
   input  logic [5:0]  amt_i,
   output logic [63:0] y_o
);

   logic [127:0] dbl;

   assign dbl = {x_i, x_i} >> amt_i;
   assign y_o = dbl[63:0];

endmodule

// File: rtl/rho_inv_round.sv
// rtl/rho_inv_round.sv - inverse Keccak rho, LANES_PER_CYCLE lanes rotated right per clock
// Optional RHO_INV_SELFCHECK_EN re-rotates each produced lane and reports mismatches on check_err.
module rho_inv_round
   import keccak_pkg::*;
#(
   parameter int LANES_PER_CYCLE = 5
) (
   input  logic           clk,
   input  logic           rst,
   rho_inv_round_if.slave bus
);

   localparam int L       = LANES_PER_CYCLE;
   localparam int G       = NUM_LANES / L;
   localparam int STATE_W = NUM_LANES * LANE_W;

   generate
      if (!(L == 1 || L == 5 || L == 25)) begin : g_bad_lpc
         $error("rho_inv_round: LANES_PER_CYCLE must be 1, 5 or 25");
      end
   endgenerate

   rho_state_e         state_q, state_d;
   logic [4:0]         cnt_q, cnt_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [STATE_W-1:0] snap_q, snap_d;
   logic [STATE_W-1:0] res_q, res_d;

   logic [4:0]         lane_idx [L];
   logic [LANE_W-1:0]  lane_in  [L];
   logic [LANE_W-1:0]  lane_out [L];
   logic               accept, step, last;

   assign accept = (state_q == ST_IDLE) && bus.start;
   assign step   = (state_q == ST_BUSY);
   assign last   = (cnt_q == 5'(G - 1));

   // Group cnt_q covers lanes cnt_q*L .. cnt_q*L+L-1.
   for (genvar j = 0; j < L; j++) begin : g_lane
      logic [LANE_W-1:0] rot_y;
      assign lane_idx[j] = 5'(int'(cnt_q) * L + j);
      assign lane_in[j]  = snap_q[lane_lsb(lane_idx[j]) +: LANE_W];
      rotr64 u_rotr (
         .x_i   (lane_in[j]),
         .amt_i (RHO_OFFSETS[lane_idx[j]]),
         .y_o   (rot_y)
      );
      assign lane_out[j] = rot_y;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      snap_d  = snap_q;
      res_d   = res_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               snap_d  = bus.state;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            for (int j = 0; j < L; j++) begin
               res_d[lane_lsb(lane_idx[j]) +: LANE_W] = lane_out[j];
            end
            cnt_d = cnt_q + 5'd1;
            if (last) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         snap_q  <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         snap_q  <= snap_d;
         res_q   <= res_d;
      end
   end

   assign bus.busy              = busy_q;
   assign bus.done              = done_q;
   assign bus.rho_inv_transform = res_q;

`ifdef RHO_INV_SELFCHECK_EN
   logic [L-1:0] mis;
   logic         err_q, err_d;
   logic         chk_q, chk_d;

   // Rotating left by r equals rotating right by (64 - r) mod 64.
   for (genvar j = 0; j < L; j++) begin : g_fwd
      logic [5:0]        fwd_amt;
      logic [LANE_W-1:0] back;
      assign fwd_amt = 6'd0 - RHO_OFFSETS[lane_idx[j]];
      rotr64 u_rotl (
         .x_i   (lane_out[j]),
         .amt_i (fwd_amt),
         .y_o   (back)
      );
      assign mis[j] = (back != lane_in[j]);
   end

   always_comb begin
      err_d = err_q;
      chk_d = chk_q;
      if (accept) begin
         err_d = 1'b0;
         chk_d = 1'b0;
      end else if (step) begin
         err_d = err_q | (|mis);
         if (last) begin
            chk_d = err_d;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
         chk_q <= 1'b0;
      end else begin
         err_q <= err_d;
         chk_q <= chk_d;
      end
   end

   assign bus.check_err = chk_q;
`else
   logic unused_sel;
   assign unused_sel    = accept ^ step;
   assign bus.check_err = 1'b0;
`endif

endmodule
